// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM among NREQ requesters with fixed 3-cycle accesses.
// Arbitration is round-robin by default; define SRAM_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module sram_port_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 8,
    parameter int DW   = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [AW*NREQ-1:0]   req_addr,
    input  logic [DW*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_done,
    output logic [DW-1:0]        rdata,
    output logic [NREQ-1:0]      grant,
    output logic                 sram_en,
    output logic [3:0]           sram_we,
    output logic [AW-1:0]        sram_addr,
    output logic [DW-1:0]        sram_di,
    input  logic [DW-1:0]        sram_do,
    output logic                 busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   sel_q, sel_d, start, pick;
    logic            rd_q, rd_d, en_q, en_d, found;
    logic [3:0]      we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   di_q, di_d, rdata_q, rdata_d;
    logic [NREQ-1:0] done_q, done_d, grant_q, grant_d;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [IW-1:0] last_q, last_d;
    assign start  = (last_q == IW'(NREQ-1)) ? '0 : last_q + 1'b1;
    assign last_d = (state_q == IDLE && found) ? pick : last_q;
    // Remember the most recent winner so the next scan starts just after it
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) last_q <= IW'(NREQ-1);
        else          last_q <= last_d;
`endif

    // Pick the first requester with a read/write op, scanning upward from start
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++)
            if (!found && req_op[2*((int'(start) + k) % NREQ)]) begin
                found = 1'b1;
                pick  = IW'((int'(start) + k) % NREQ);
            end
    end

    // Next-state and registered outputs for the IDLE -> ACCESS -> DONE sequence
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        en_d    = en_q;
        we_d    = we_q;
        addr_d  = addr_q;
        di_d    = di_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = ACCESS;
                sel_d   = pick;
                rd_d    = ~req_op[2*int'(pick)+1];
                en_d    = 1'b1;
                we_d    = {4{req_op[2*int'(pick)+1]}};
                addr_d  = req_addr[AW*int'(pick) +: AW];
                di_d    = req_wdata[DW*int'(pick) +: DW];
                grant_d = NREQ'(1) << pick;
            end
            ACCESS: begin
                state_d = DONE;
                en_d    = 1'b0;
                we_d    = 4'b0000;
                rdata_d = rd_q ? sram_do : rdata_q;
                done_d  = NREQ'(1) << sel_q;
            end
            default: begin
                state_d = IDLE;
                done_d  = '0;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rd_q    <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 4'b0000;
            addr_q  <= '0;
            di_q    <= '0;
            rdata_q <= '0;
            done_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            grant_q <= grant_d;
        end

    assign req_done  = done_q;
    assign rdata     = rdata_q;
    assign grant     = grant_q;
    assign sram_en   = en_q;
    assign sram_we   = we_q;
    assign sram_addr = addr_q;
    assign sram_di   = di_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scoreboard bench for sram_port_arbiter with a behavioural SRAM.
module tb_sram_port_arbiter;
    typedef struct {
        int          idx;
        logic [31:0] data;
        bit          rd;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  req_op = '0;
    logic [23:0] req_addr = '0;
    logic [95:0] req_wdata = '0;
    logic [2:0]  req_done, grant;
    logic [31:0] rdata, sram_di, sram_do;
    logic        sram_en, busy;
    logic [3:0]  sram_we;
    logic [7:0]  sram_addr;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    exp_t        sb [$];
    int          n_cmp = 0, n_bad = 0, cyc = 0, en_cnt = 0, g_cnt = 0;
    bit          hold = 1'b0;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_done(req_done), .rdata(rdata), .grant(grant),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_di(sram_di),
        .sram_do(sram_do), .busy(busy)
    );

    // SRAM model: samples mid-cycle so Do is ready at the end of the access cycle
    always @(negedge clk)
        if (sram_en) begin
            if (sram_we == 4'hf) mem[sram_addr] <= sram_di;
            sram_do <= mem[sram_addr];
        end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic expect_done(input int i, input bit rd, input logic [31:0] d, input int due);
        sb.push_back('{i, d, rd, due});
    endtask

    task automatic issue(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d, input int due);
        req_op[2*i +: 2] = wr ? 2'b11 : 2'b01;
        req_addr[8*i +: 8] = a;
        req_wdata[32*i +: 32] = d;
        if (wr) ref_mem[a] = d;
        expect_done(i, !wr, ref_mem[a], due);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (sram_en) en_cnt++;
        if (grant != 3'b000) g_cnt++;
        for (int i = 0; i < 3; i++)
            if (req_done[i]) begin
                if (sb.size() == 0) check("unexpected_done", i, 99);
                else begin
                    e = sb.pop_front();
                    check("done_idx", i, e.idx);
                    check("done_cycle", cyc, e.due);
                    if (e.rd) check("rdata", rdata, e.data);
                end
                if (!hold) req_op[2*i +: 2] = 2'b00;
            end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_en", sram_en, 0);
        check("rst_we", sram_we, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_di", sram_di, 0);
        check("rst_rdata", rdata, 0);
        check("rst_done", req_done, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        en_cnt = 0;
        issue(1, 1, 8'h10, 32'hDEADBEEF, cyc + 2);
        tick();
        check("wr_en", sram_en, 1);
        check("wr_we", sram_we, 4'hf);
        check("wr_addr", sram_addr, 8'h10);
        check("wr_di", sram_di, 32'hDEADBEEF);
        check("wr_grant", grant, 3'b010);
        check("wr_busy", busy, 1);
        drain(10);
        check("wr_en_cycles", en_cnt, 1);
        check("wr_rdata_kept", rdata, 0);
        check("idle_busy", busy, 0);

        issue(0, 0, 8'h10, 32'h0, cyc + 2);
        drain(10);
        issue(0, 1, 8'h30, 32'h12345678, cyc + 2);
        drain(10);
        issue(2, 1, 8'h20, 32'hCAFEF00D, cyc + 2);
        drain(10);
        check("rdata_hold", rdata, 32'hDEADBEEF);

        issue(0, 0, 8'h30, 32'h0, cyc + 2);
        issue(1, 0, 8'h20, 32'h0, cyc + 5);
        issue(2, 0, 8'h10, 32'h0, cyc + 8);
        tick();
        tick();
        issue(0, 0, 8'h20, 32'h0, cyc + 9);
        drain(20);

        en_cnt = 0;
        g_cnt = 0;
        req_op[1:0] = 2'b10;
        repeat (10) tick();
        check("rsv_en", en_cnt, 0);
        check("rsv_grant", g_cnt, 0);
        check("rsv_busy", busy, 0);
        req_op[1:0] = 2'b00;
        tick();

        req_op[1:0] = 2'b01;
        req_addr[7:0] = 8'h30;
        tick();
        check("mid_grant", grant, 3'b001);
        check("mid_busy", busy, 1);
        req_op[3:2] = 2'b01;
        req_addr[15:8] = 8'h20;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_en", sram_en, 0);
        check("mid_rst_we", sram_we, 0);
        check("mid_rst_done", req_done, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        expect_done(0, 1, ref_mem[8'h30], cyc + 2);
        expect_done(1, 1, ref_mem[8'h20], cyc + 5);
        drain(20);

        hold = 1'b1;
        req_op[1:0] = 2'b01;
        req_addr[7:0] = 8'h10;
        req_op[5:4] = 2'b01;
        req_addr[23:16] = 8'h20;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        for (int r = 0; r < 4; r++) expect_done(0, 1, ref_mem[8'h10], cyc + 2 + 3*r);
`else
        for (int r = 0; r < 4; r++)
            expect_done(r[0] ? 0 : 2, 1, r[0] ? ref_mem[8'h10] : ref_mem[8'h20], cyc + 2 + 3*r);
`endif
        repeat (11) tick();
        check("hold_sb", sb.size(), 0);
        hold = 1'b0;
        req_op[1:0] = 2'b00;
        expect_done(2, 1, ref_mem[8'h20], cyc + 3);
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
